// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file write arbiter.
package regfile_arb_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        ARB_NORMAL = 1'b0,
        ARB_FORCE  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/io_wr_fifo.sv
// Small power-of-two FIFO holding queued I/O register writes as {rd, data}.
module io_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && (r_count != CNT_W'(DEPTH));
    assign w_do_pop  = i_pop && (r_count != '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between pipeline writeback and queued I/O writes,
// with a starvation timer that forces an I/O slot by stalling writeback for one cycle.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int IO_DEPTH = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        wb_en,
    input  logic [REG_W-1:0]            wb_rd,
    input  logic [DATA_W-1:0]           wb_data,
    input  logic                        io_valid,
    input  logic [REG_W-1:0]            io_rd,
    input  logic [DATA_W-1:0]           io_data,
    output logic                        io_ready,
    output logic                        stall_wb,
    output logic                        ren_out,
    output logic [REG_W-1:0]            rd_out,
    output logic [DATA_W-1:0]           data_out,
    output logic [$clog2(IO_DEPTH):0]   fifo_count
);

    localparam int CNT_W  = $clog2(IO_DEPTH) + 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam int ENT_W  = REG_W + DATA_W;

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_nxt;
    logic [CNT_W-1:0]  w_count;
    logic [ENT_W-1:0]  w_head;
    logic              w_empty;
    logic              w_push;
    logic              w_grant_io;
    logic              w_wb_write;

    assign w_empty    = (w_count == '0);
    assign io_ready   = (w_count < CNT_W'(IO_DEPTH));
    assign fifo_count = w_count;
    assign w_wb_write = wb_en && (wb_rd != REG_ZERO);
    // r0 writes are acknowledged to the requester but never queued.
    assign w_push     = io_valid && io_ready && (io_rd != REG_ZERO);

    io_wr_fifo #(
        .DEPTH (IO_DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .i_clk   (clock),
        .i_rst   (reset),
        .i_push  (w_push),
        .i_data  ({io_rd, io_data}),
        .i_pop   (w_grant_io),
        .o_head  (w_head),
        .o_count (w_count)
    );

    always_comb begin
        w_grant_io = 1'b0;
        stall_wb   = 1'b0;
        ren_out    = 1'b0;
        rd_out     = '0;
        data_out   = '0;
        if (!reset) begin
            if ((r_state == ARB_FORCE) && !w_empty) begin
                w_grant_io = 1'b1;
                stall_wb   = 1'b1;
            end else if (w_wb_write) begin
                ren_out  = 1'b1;
                rd_out   = wb_rd;
                data_out = wb_data;
            end else if (!w_empty) begin
                w_grant_io = 1'b1;
            end
            if (w_grant_io) begin
                ren_out  = 1'b1;
                rd_out   = w_head[ENT_W-1:DATA_W];
                data_out = w_head[DATA_W-1:0];
            end
        end
    end

    always_comb begin
        w_wait_nxt  = r_wait_cnt;
        w_state_nxt = r_state;
        if (w_empty || w_grant_io) begin
            w_wait_nxt = '0;
        end else if (r_wait_cnt != WAIT_W'(MAX_WAIT)) begin
            w_wait_nxt = r_wait_cnt + WAIT_W'(1);
        end
        case (r_state)
            ARB_NORMAL: if (w_wait_nxt == WAIT_W'(MAX_WAIT)) w_state_nxt = ARB_FORCE;
            ARB_FORCE:  w_state_nxt = ARB_NORMAL;
            default:    w_state_nxt = ARB_NORMAL;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ARB_NORMAL;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_regfile_write_arbiter;

    localparam int IO_DEPTH = 4;
    localparam int MAX_WAIT = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        io_valid = 1'b0;
    logic [4:0]  io_rd = '0;
    logic [31:0] io_data = '0;
    logic        io_ready;
    logic        stall_wb;
    logic        ren_out;
    logic [4:0]  rd_out;
    logic [31:0] data_out;
    logic [2:0]  fifo_count;

    int checks = 0;
    int failures = 0;
    bit model_en = 1'b0;

    logic [36:0] q[$];
    int          starve = 0;

    regfile_write_arbiter #(
        .IO_DEPTH (IO_DEPTH),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .wb_en      (wb_en),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .io_valid   (io_valid),
        .io_rd      (io_rd),
        .io_data    (io_data),
        .io_ready   (io_ready),
        .stall_wb   (stall_wb),
        .ren_out    (ren_out),
        .rd_out     (rd_out),
        .data_out   (data_out),
        .fifo_count (fifo_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reference model: evaluated mid-cycle, then advanced to represent the coming edge.
    always @(negedge clock) begin
        if (model_en) begin
            if (reset) begin
                q.delete();
                starve = 0;
                chk("m_ren", ren_out, 0);
                chk("m_stall", stall_wb, 0);
                chk("m_rd", rd_out, 0);
                chk("m_data", data_out, 0);
                chk("m_ready", io_ready, 1);
                chk("m_count", fifo_count, 0);
            end else begin
                bit          forced;
                bit          io_win;
                bit          e_ren;
                logic [4:0]  e_rd;
                logic [31:0] e_data;
                int          size0;
                size0  = q.size();
                forced = (starve >= MAX_WAIT) && (size0 > 0);
                io_win = forced || (!(wb_en && wb_rd != 0) && size0 > 0);
                e_ren  = 1'b0;
                e_rd   = '0;
                e_data = '0;
                if (io_win) begin
                    e_ren  = 1'b1;
                    e_rd   = q[0][36:32];
                    e_data = q[0][31:0];
                end else if (wb_en && wb_rd != 0) begin
                    e_ren  = 1'b1;
                    e_rd   = wb_rd;
                    e_data = wb_data;
                end
                chk("m_ren", ren_out, e_ren);
                chk("m_stall", stall_wb, forced);
                chk("m_rd", rd_out, e_rd);
                chk("m_data", data_out, e_data);
                chk("m_ready", io_ready, size0 < IO_DEPTH);
                chk("m_count", fifo_count, size0);
                if (io_win) void'(q.pop_front());
                if (size0 == 0 || io_win) starve = 0;
                else if (starve < MAX_WAIT) starve = starve + 1;
                if (io_valid && size0 < IO_DEPTH && io_rd != 0) q.push_back({io_rd, io_data});
            end
        end
    end

    initial begin
        step();
        step();
        chk("rst_count", fifo_count, 0);
        chk("rst_ready", io_ready, 1);
        chk("rst_ren", ren_out, 0);
        chk("rst_stall", stall_wb, 0);
        reset = 1'b0;
        model_en = 1'b1;
        step();

        // WB wins over a same-cycle I/O push; the I/O write follows on the idle cycle
        wb_en = 1; wb_rd = 5; wb_data = 32'hA5;
        io_valid = 1; io_rd = 7; io_data = 32'h11;
        #1;
        chk("prio_ren", ren_out, 1);
        chk("prio_rd", rd_out, 5);
        chk("prio_data", data_out, 32'hA5);
        step();
        wb_en = 0; io_valid = 0;
        #1;
        chk("prio_io_ren", ren_out, 1);
        chk("prio_io_rd", rd_out, 7);
        chk("prio_io_data", data_out, 32'h11);
        step();

        // r0 filter on both sides
        wb_en = 1; wb_rd = 0; wb_data = 32'hFF;
        io_valid = 1; io_rd = 0; io_data = 32'h77;
        #1;
        chk("r0_ren", ren_out, 0);
        chk("r0_stall", stall_wb, 0);
        chk("r0_ready", io_ready, 1);
        step();
        wb_en = 0; io_valid = 0;
        #1;
        chk("r0_count", fifo_count, 0);
        step();

        // Fill the FIFO under continuous writeback; 5th request must be refused
        wb_en = 1; wb_rd = 3; wb_data = 32'h33;
        for (int i = 0; i < 4; i++) begin
            io_valid = 1; io_rd = 5'(i + 1); io_data = 32'h200 + 32'(i);
            #1;
            chk("full_ready_pre", io_ready, 1);
            step();
        end
        io_valid = 1; io_rd = 9; io_data = 32'h999;
        #1;
        chk("full_count", fifo_count, 4);
        chk("full_ready", io_ready, 0);
        chk("full_wb_rd", rd_out, 3);
        step();
        wb_en = 0; io_valid = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_rd", rd_out, 32'(i + 1));
            chk("drain_data", data_out, 32'h200 + 32'(i));
            step();
        end
        chk("drain_empty", fifo_count, 0);

        // Starvation: one queued entry behind continuous writeback
        wb_en = 1; wb_rd = 2; wb_data = 32'h22;
        io_valid = 1; io_rd = 12; io_data = 32'hC0DE;
        step();
        io_valid = 0;
        for (int i = 0; i < MAX_WAIT; i++) begin
            #1;
            chk("starve_nostall", stall_wb, 0);
            chk("starve_wb_rd", rd_out, 2);
            step();
        end
        #1;
        chk("force_stall", stall_wb, 1);
        chk("force_ren", ren_out, 1);
        chk("force_rd", rd_out, 12);
        chk("force_data", data_out, 32'hC0DE);
        step();
        #1;
        chk("resume_stall", stall_wb, 0);
        chk("resume_rd", rd_out, 2);
        chk("resume_count", fifo_count, 0);
        step();
        wb_en = 0;

        // Wrap: back-to-back push/pop pairs with no writeback
        for (int i = 0; i <= 10; i++) begin
            if (i < 10) begin
                io_valid = 1; io_rd = 5'(i + 1); io_data = 32'h100 + 32'(i);
            end else begin
                io_valid = 0;
            end
            #1;
            if (i > 0) begin
                chk("wrap_rd", rd_out, 32'(i));
                chk("wrap_data", data_out, 32'h100 + 32'(i - 1));
            end
            chk("wrap_cnt_le1", 32'(fifo_count <= 1), 1);
            step();
        end
        io_valid = 0;

        // Reset with three entries queued
        wb_en = 1; wb_rd = 4; wb_data = 32'h44;
        for (int i = 0; i < 3; i++) begin
            io_valid = 1; io_rd = 5'(20 + i); io_data = 32'h300 + 32'(i);
            step();
        end
        io_valid = 0;
        #1;
        chk("pre_rst_count", fifo_count, 3);
        reset = 1;
        #1;
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_ren", ren_out, 0);
        chk("mid_rst_stall", stall_wb, 0);
        chk("mid_rst_ready", io_ready, 1);
        step();
        step();
        reset = 0;
        wb_en = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            chk("post_rst_ren", ren_out, 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
